// File: rtl/reg_sipo_rx.sv
// Serial-in, parallel-out receiver: assembles N-bit words LSB- or MSB-first and
// presents each completed word on Q behind a valid/ready handshake.
module reg_sipo_rx #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 dir,
    input  logic                 D,
    input  logic                 clear,
    input  logic                 ready,
    output logic [N-1:0]         Q,
    output logic                 valid,
    output logic                 overrun,
    output logic [$clog2(N)-1:0] bit_cnt
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastBit = CW'(N - 1);

    typedef enum logic [0:0] {
        StIdleWord,
        StCollect
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N-1:0]   sreg_q, sreg_d;
    logic           dir_q, dir_d;
    logic [N-1:0]   q_q, q_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;

    logic           shift_dir;
    logic [N-1:0]   shifted;
    logic           word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdleWord;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            dir_q     <= 1'b1;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // The first bit of a word uses the live dir input; later bits use the latched copy.
    always_comb begin
        shift_dir = (state_q == StIdleWord) ? dir : dir_q;
        shifted   = shift_dir ? {D, sreg_q[N-1:1]} : {sreg_q[N-2:0], D};
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        dir_d     = dir_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        word_done = 1'b0;

        if (clear) begin
            state_d   = StIdleWord;
            bit_cnt_d = '0;
            sreg_d    = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (valid_q && ready) begin
                valid_d = 1'b0;
            end

            if (enable) begin
                sreg_d = shifted;
                unique case (state_q)
                    StIdleWord: begin
                        dir_d     = dir;
                        bit_cnt_d = CW'(1);
                        state_d   = StCollect;
                    end
                    StCollect: begin
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_d = '0;
                            state_d   = StIdleWord;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        bit_cnt_d = '0;
                        state_d   = StIdleWord;
                    end
                endcase

                // A completed word may replace Q only if Q is free or leaving this edge.
                if (word_done) begin
                    if (!valid_q || ready) begin
                        q_d     = shifted;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        end
    end

    assign Q       = q_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_reg_sipo_rx.sv
// Directed bench for reg_sipo_rx (N=8): bit order, handshake, overrun, clear, async reset.
module tb_reg_sipo_rx;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       dir;
    logic       D;
    logic       clear;
    logic       ready;
    logic [7:0] Q;
    logic       valid;
    logic       overrun;
    logic [2:0] bit_cnt;

    int tests;
    int fails;

    reg_sipo_rx #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .dir     (dir),
        .D       (D),
        .clear   (clear),
        .ready   (ready),
        .Q       (Q),
        .valid   (valid),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends w MSB-first (bit 7 first) with the given dir and ready levels.
    task automatic send_msb(input logic [7:0] w, input logic d, input logic r);
        for (int i = 7; i >= 0; i--) begin
            enable = 1'b1;
            dir    = d;
            D      = w[i];
            ready  = r;
            step();
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({Q, valid, overrun, bit_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state: Q=%h valid=%b overrun=%b bit_cnt=%0d, want all 0",
                     Q, valid, overrun, bit_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq   = 8'b0111_1000;  // seq[i] is the i-th bit sent: 0,0,0,1,1,1,1,0
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1;
            dir    = 1'b0;
            D      = seq[i];
            step();
            tests++;
            if (bit_cnt !== 3'((i + 1) % 8)) begin
                fails++;
                $display("FAIL msb_bit_cnt[%0d]: got %0d want %0d", i, bit_cnt, (i + 1) % 8);
            end
            if (i == 6) begin
                tests++;
                if (valid !== 1'b0) begin
                    fails++;
                    $display("FAIL msb_valid_early: got %b want 0", valid);
                end
            end
        end
        enable = 1'b0;
        tests++;
        if (valid !== 1'b1 || Q !== 8'h1E) begin
            fails++;
            $display("FAIL msb_word: valid=%b Q=%h, want 1 / 1e", valid, Q);
        end
        step();
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL msb_pulse: valid=%b want 0", valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        seq   = 8'b0111_1000;
        ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                enable = 1'b1;
                // On the second pass dir flips to MSB-first after bit 3.
                dir    = (pass == 1 && i >= 3) ? 1'b0 : 1'b1;
                D      = seq[i];
                step();
            end
            enable = 1'b0;
            tests++;
            if (valid !== 1'b1 || Q !== 8'h78) begin
                fails++;
                $display("FAIL lsb_word_pass%0d: valid=%b Q=%h, want 1 / 78", pass, valid, Q);
            end
            step();
        end
    endtask

    task automatic test_overrun();
        send_msb(8'hA5, 1'b0, 1'b0);
        tests++;
        if (valid !== 1'b1 || Q !== 8'hA5 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_first: valid=%b Q=%h overrun=%b, want 1 / a5 / 0",
                     valid, Q, overrun);
        end
        send_msb(8'h3C, 1'b0, 1'b0);
        tests++;
        if (valid !== 1'b1 || Q !== 8'hA5 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_second: valid=%b Q=%h overrun=%b, want 1 / a5 / 1",
                     valid, Q, overrun);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        tests++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_accept: valid=%b overrun=%b, want 0 / 1", valid, overrun);
        end
        step();
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_sticky: overrun=%b want 1", overrun);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        tests++;
        if (overrun !== 1'b0 || Q !== 8'hA5) begin
            fails++;
            $display("FAIL ovr_clear: overrun=%b Q=%h, want 0 / a5", overrun, Q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        send_msb(8'h11, 1'b0, 1'b0);
        w = 8'h22;
        for (int i = 7; i >= 0; i--) begin
            enable = 1'b1;
            dir    = 1'b0;
            D      = w[i];
            ready  = (i == 0);
            step();
            if (i == 1) begin
                tests++;
                if (valid !== 1'b1 || Q !== 8'h11) begin
                    fails++;
                    $display("FAIL b2b_hold: valid=%b Q=%h, want 1 / 11", valid, Q);
                end
            end
        end
        enable = 1'b0;
        ready  = 1'b0;
        tests++;
        if (valid !== 1'b1 || Q !== 8'h22 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_same_edge: valid=%b Q=%h overrun=%b, want 1 / 22 / 0",
                     valid, Q, overrun);
        end
        ready = 1'b1;
        step();
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_consume: valid=%b want 0", valid);
        end
        // Continuous words with ready high: each completes with no overrun.
        send_msb(8'h5A, 1'b1, 1'b1);
        send_msb(8'hC3, 1'b0, 1'b1);
        tests++;
        if (valid !== 1'b1 || Q !== 8'hC3 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stream: valid=%b Q=%h overrun=%b, want 1 / c3 / 0",
                     valid, Q, overrun);
        end
        step();
    endtask

    task automatic test_clear();
        logic [7:0] part;
        part  = 8'b0001_0101;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1;
            dir    = 1'b0;
            D      = part[i];
            step();
        end
        tests++;
        if (bit_cnt !== 3'd5) begin
            fails++;
            $display("FAIL clr_partial_cnt: got %0d want 5", bit_cnt);
        end
        clear  = 1'b1;
        enable = 1'b1;
        D      = 1'b1;
        step();
        clear  = 1'b0;
        enable = 1'b0;
        tests++;
        if (bit_cnt !== 3'd0 || valid !== 1'b0 || Q !== 8'hC3) begin
            fails++;
            $display("FAIL clr_edge: bit_cnt=%0d valid=%b Q=%h, want 0 / 0 / c3",
                     bit_cnt, valid, Q);
        end
        send_msb(8'hFF, 1'b0, 1'b1);
        tests++;
        if (valid !== 1'b1 || Q !== 8'hFF) begin
            fails++;
            $display("FAIL clr_new_word: valid=%b Q=%h, want 1 / ff", valid, Q);
        end
        step();
    endtask

    task automatic test_async_reset();
        send_msb(8'h0F, 1'b0, 1'b0);
        send_msb(8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            D      = 1'b1;
            step();
        end
        enable = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({Q, valid, overrun, bit_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset: Q=%h valid=%b overrun=%b bit_cnt=%0d, want all 0",
                     Q, valid, overrun, bit_cnt);
        end
        #2;
        rst_n = 1'b1;
        step();
        send_msb(8'h81, 1'b0, 1'b1);
        tests++;
        if (valid !== 1'b1 || Q !== 8'h81 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_word: valid=%b Q=%h overrun=%b, want 1 / 81 / 0",
                     valid, Q, overrun);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        enable = 1'b0;
        dir    = 1'b1;
        D      = 1'b0;
        clear  = 1'b0;
        ready  = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
